// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer.
// in_ready comes straight from a flop, so execute-side back-pressure never
// reaches decode combinationally. Also carries a branch-mispredict flush and
// a saturating stall-cycle counter for performance debug.
//
// in_ctrl packing (LSB-aligned concatenation; bit 20 is spare and passes through):
//   [19] RegWrite  [18:15] ALUctrl  [14] ALUsrc  [13] PCsrc  [12] destsrc
//   [11:9] memCtrl [8] MemWrite [7] UI_control [6] RD1_control
//   [5] PC_RD1_control [4] four_imm_control [3] mul_sel [2:0] ImmSrc
module id_ex_skid_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [20:0]      in_ctrl,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rd1,
    input  logic [XLEN-1:0]  in_rd2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_ctrl,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rd1,
    output logic [XLEN-1:0]  out_rd2,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PW = 21 + 4 * XLEN + 15;

    localparam int unsigned B_REGWRITE = 19;
    localparam int unsigned B_PCSRC    = 13;
    localparam int unsigned B_MEMWRITE = 8;
    localparam int unsigned B_MULSEL   = 3;

    // Side-effect bits that must never leak to execute while no entry is valid
    localparam logic [20:0] GATE_MASK = (21'd1 << B_REGWRITE) | (21'd1 << B_PCSRC)
                                      | (21'd1 << B_MEMWRITE) | (21'd1 << B_MULSEL);

    logic [PW-1:0]    in_bundle;
    logic [PW-1:0]    m_data;
    logic [PW-1:0]    s_data;
    logic             m_valid;
    logic             s_valid;
    logic             in_ready_q;
    logic             acc;
    logic             drain;
    logic [20:0]      m_ctrl;
    logic [CNT_W-1:0] stall_q;

    assign in_bundle = {in_ctrl, in_pc, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd};
    assign acc       = in_valid & in_ready_q;
    assign drain     = ~m_valid | out_ready;

    // Entry movement: input -> M directly when M drains, otherwise into S;
    // S always refills M before any new input is taken.
    // in_ready_q is kept as its own flop, always equal to !s_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
            m_data     <= '0;
            s_data     <= '0;
        end else if (flush) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (s_valid) begin
            if (drain) begin
                m_data     <= s_data;
                m_valid    <= 1'b1;
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else if (acc) begin
            if (drain) begin
                m_data  <= in_bundle;
                m_valid <= 1'b1;
            end else begin
                s_data     <= in_bundle;
                s_valid    <= 1'b1;
                in_ready_q <= 1'b0;
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where execute holds off a valid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (clr_stats) begin
            stall_q <= '0;
        end else if (m_valid && !out_ready && !flush && !(&stall_q)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign {m_ctrl, out_pc, out_rd1, out_rd2, out_imm, out_rs1, out_rs2, out_rd} = m_data;

    assign out_ctrl  = m_valid ? m_ctrl : (m_ctrl & ~GATE_MASK);
    assign out_valid = m_valid;
    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed scenarios plus randomized traffic,
// checked against a queue-based model of a 2-deep in-order buffer.
module tb_id_ex_skid_reg;

    localparam int unsigned XLEN = 32;
    localparam logic [20:0] GATE = (21'd1 << 19) | (21'd1 << 13) | (21'd1 << 8) | (21'd1 << 3);

    typedef struct packed {
        logic [20:0]     ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n, flush, clr_stats, in_valid, out_ready;
    logic [20:0] in_ctrl;
    logic [XLEN-1:0] in_pc, in_rd1, in_rd2, in_imm;
    logic [4:0] in_rs1, in_rs2, in_rd;

    logic in_ready, out_valid;
    logic [20:0] out_ctrl;
    logic [XLEN-1:0] out_pc, out_rd1, out_rd2, out_imm;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic [15:0] stall_cnt;

    logic in_ready_b, out_valid_b;
    logic [20:0] out_ctrl_b;
    logic [XLEN-1:0] out_pc_b, out_rd1_b, out_rd2_b, out_imm_b;
    logic [4:0] out_rs1_b, out_rs2_b, out_rd_b;
    logic [1:0] stall_cnt_b;

    always #5 clk = ~clk;

    id_ex_skid_reg #(.XLEN(XLEN), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .stall_cnt(stall_cnt)
    );

    id_ex_skid_reg #(.XLEN(XLEN), .CNT_W(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl),
        .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
        .out_pc(out_pc_b), .out_rd1(out_rd1_b), .out_rd2(out_rd2_b), .out_imm(out_imm_b),
        .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b),
        .stall_cnt(stall_cnt_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: in-order queue holding at most two entries
    ent_t q[$];
    int   cnt_big   = 0;
    int   cnt_small = 0;
    bit   last_acc  = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t cur_in();
        ent_t e;
        e.ctrl = in_ctrl; e.pc = in_pc; e.rd1 = in_rd1; e.rd2 = in_rd2; e.imm = in_imm;
        e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
        return e;
    endfunction

    task automatic model_step();
        int  sz;
        bit  acc;
        sz  = q.size();
        acc = in_valid && (sz < 2);
        last_acc = acc;
        if (clr_stats) begin
            cnt_big = 0; cnt_small = 0;
        end else if (sz > 0 && !out_ready && !flush) begin
            if (cnt_big < 65535) cnt_big++;
            if (cnt_small < 3) cnt_small++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(cur_in());
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready_small", in_ready_b, q.size() < 2);
        if (q.size() > 0)
            chk("payload", {out_ctrl, out_pc, out_rd1, out_rd2, out_imm, out_rs1, out_rs2, out_rd}, q[0]);
        else
            chk("gated_bits", out_ctrl & GATE, 21'd0);
        chk("stall_cnt", stall_cnt, cnt_big);
        chk("stall_cnt_small", stall_cnt_b, cnt_small);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_payload();
        in_ctrl = 21'($urandom);
        in_pc   = $urandom; in_rd1 = $urandom; in_rd2 = $urandom; in_imm = $urandom;
        in_rs1  = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
    endtask

    task automatic drive(input logic iv, input logic [XLEN-1:0] pc, input logic ordy);
        rand_payload();
        in_valid = iv; in_pc = pc; out_ready = ordy;
        flush = 1'b0; clr_stats = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; clr_stats = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rand_payload();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_ctrl", out_ctrl, 21'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_stall", stall_cnt, 16'd0);
        rst_n = 1'b1;

        // Streaming with out_ready high: one entry per cycle, 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1);
            cycle();
            chk("stream_pc", out_pc, 32'(i * 4));
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_ready", in_ready, 1'b1);
        end

        // Asynchronous reset mid-cycle while an entry is valid
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_ctrl", out_ctrl, 21'd0);
        chk("arst_stall", stall_cnt, 16'd0);
        q.delete(); cnt_big = 0; cnt_small = 0;
        rst_n = 1'b1;

        // Back-pressure: 0x100 into M, 0x104 into S, 0x108 held by the source
        drive(1'b1, 32'h100, 1'b1); cycle();
        drive(1'b1, 32'h104, 1'b0); cycle();
        chk("bp_m_pc", out_pc, 32'h100);
        chk("bp_in_ready", in_ready, 1'b0);
        drive(1'b1, 32'h108, 1'b0); cycle();
        chk("bp_hold_pc", out_pc, 32'h100);
        chk("bp_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1; cycle();
        chk("bp_rel_pc1", out_pc, 32'h104);
        cycle();
        chk("bp_rel_pc2", out_pc, 32'h108);
        drive(1'b0, 32'h0, 1'b1); cycle();
        chk("bp_empty", out_valid, 1'b0);

        // Stall counter: clear, load one entry, hold it for 5 then 6 cycles
        drive(1'b0, 32'h0, 1'b0); clr_stats = 1'b1; cycle();
        drive(1'b1, 32'h200, 1'b0); cycle();
        drive(1'b0, 32'h0, 1'b0);
        repeat (5) cycle();
        chk("stall_5", stall_cnt, 16'd5);
        chk("stall_5_sat", stall_cnt_b, 2'd3);
        cycle();
        chk("stall_6", stall_cnt, 16'd6);
        chk("stall_6_sat", stall_cnt_b, 2'd3);
        clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
        chk("stall_clr", stall_cnt, 16'd0);
        chk("stall_clr_small", stall_cnt_b, 2'd0);

        // Flush with both entries full and a new input offered
        drive(1'b1, 32'h300, 1'b0); cycle();
        chk("fl_full", in_ready, 1'b0);
        drive(1'b1, 32'h304, 1'b0); flush = 1'b1; cycle();
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        repeat (3) cycle();

        // Gating: all-ones control drains, stale payload shows with side effects masked
        drive(1'b1, 32'h400, 1'b1); in_ctrl = '1; cycle();
        chk("gate_live", out_ctrl, 21'h1FFFFF);
        drive(1'b0, 32'h0, 1'b1); cycle();
        chk("gate_valid", out_valid, 1'b0);
        chk("gate_ctrl", out_ctrl, 21'h1FFFFF & ~GATE);
        chk("gate_aluctrl", out_ctrl[18:15], 4'hF);

        // Randomized traffic; source holds an offered entry until accepted
        in_valid = 1'b0; last_acc = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (last_acc || !in_valid) begin
                rand_payload();
                in_valid = ($urandom % 4) != 0;
            end
            out_ready = (n % 100 < 50) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            flush     = ($urandom % 30) == 0;
            clr_stats = ($urandom % 80) == 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Decode-to-execute pipeline boundary of the pipelined core.
- Captures the decoder's control bundle together with PC, register-file read data, immediate and register indices, and presents them to the execute stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from execute (multi-cycle multiply, cache-miss stall) never puts a combinational path on `in_ready`.
- Supports a branch-mispredict flush and a saturating stall-cycle counter for performance debug.

Parameters:
- XLEN, 32, width of PC/data/immediate fields
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill all held and incoming entries this cycle
- clr_stats  in  1  synchronous clear of stall counter
- in_valid  in  1  decode entry valid
- in_ready  out  1  block can accept this cycle
- in_ctrl  in  21  {RegWrite, ALUctrl[3:0], ALUsrc, PCsrc, destsrc, memCtrl[2:0], MemWrite, UI_control, RD1_control, PC_RD1_control, four_imm_control, mul_sel, ImmSrc[2:0]}
- in_pc, in_rd1, in_rd2, in_imm  in  XLEN each  decode payload
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- out_valid  out  1  execute entry valid
- out_ready  in  1  execute consumes entry this cycle
- out_ctrl  out  21  same packing as in_ctrl, side-effect bits gated (see below)
- out_pc, out_rd1, out_rd2, out_imm  out  XLEN each
- out_rs1, out_rs2, out_rd  out  5 each
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- **Storage:** main entry M drives the outputs; skid entry S. Flags m_valid and s_valid.
  - out_valid = m_valid.
  - in_ready = !s_valid, a pure register output.
- **Event definitions:**
  - acc = in_valid & in_ready.
  - drain = !m_valid | out_ready.
- **Priority 1, flush = 1:** m_valid <= 0 and s_valid <= 0; the incoming entry is dropped. Payload registers may hold stale data.
- **Priority 2, flush = 0:**
  - s_valid & drain: M <= S, m_valid <= 1, s_valid <= 0. No accept is possible that cycle, since in_ready = 0.
  - !s_valid & acc & drain: M <= input, m_valid <= 1.
  - !s_valid & acc & !drain: S <= input, s_valid <= 1; M holds.
  - !s_valid & !acc & out_ready: m_valid <= 0.
  - Otherwise all state holds.
- **Ordering:** entries leave in arrival order. No entry is duplicated or lost unless flushed.
- **Latency/throughput:** empty block gives input-to-output latency of 1 cycle. Steady-state throughput is 1 entry/cycle with out_ready held high.
- **Capacity:** after one back-pressure cycle, in_ready deasserts on the next cycle and stays low until S moves into M.
- **Output gating:** when out_valid = 0, the RegWrite, MemWrite, PCsrc and mul_sel fields of out_ctrl are forced to 0. All other fields and data outputs show M's payload unchanged.
- **stall_cnt:**
  - +1 each cycle m_valid & !out_ready & !flush.
  - Saturates at all-ones.
  - clr_stats takes priority over increment and sets it to 0.
  - Flush does not clear it.
- **Reset (rst_n low, async):**
  - m_valid = s_valid = 0, so out_valid = 0.
  - in_ready = 1.
  - All payload registers = 0, out_ctrl = 0, stall_cnt = 0.
  - Reset mid-transfer discards both entries. First acceptance is possible on the first edge after rst_n rises.
- **Simultaneous events:**
  - flush with acc: input is dropped, in_ready = 1 next cycle.
  - flush with out_ready: execute treats that cycle's out entry as consumed. No further entry appears.

Test Plan:
- **Reset/idle:** assert rst_n = 0 mid-cycle with out_valid = 1 -> out_valid = 0, in_ready = 1, out_ctrl = 0, stall_cnt = 0 immediately, without waiting for a clock edge.
- **Streaming:** in_valid = 1 for 8 cycles with in_pc = 0x0, 0x4 … 0x1C and out_ready = 1 -> out_pc = 0x0 … 0x1C on consecutive cycles, 1-cycle latency, in_ready stays 1.
- **Back-pressure:**
  - Drive in_pc 0x100, 0x104, 0x108 back-to-back with out_ready = 0 from the second cycle -> 0x100 in M, 0x104 in S, in_ready = 0, 0x108 held by source.
  - Then release out_ready -> out_pc sequence is 0x100, 0x104, 0x108 with none lost.
- **Stall counter:**
  - Hold m_valid with out_ready = 0 for 5 cycles -> stall_cnt = 5.
  - With CNT_W = 2, 6 cycles -> stall_cnt = 3 (saturates).
  - Pulsing clr_stats -> 0.
- **Flush:** with both entries full and in_valid = 1, pulse flush -> next cycle out_valid = 0, in_ready = 1, and no flushed PC ever appears on out_pc.
- **Gating:** drive in_ctrl all-ones, then in_valid = 0 and out_ready = 1 for one cycle -> the cycle after draining shows out_valid = 0 with RegWrite/MemWrite/PCsrc/mul_sel = 0 while ALUctrl = 4'hF.
